alu_seq_n: RTL and testbench
============================

# alu_seq_n

Parametrised, handshaked successor to the 4-bit combinational ALU. It takes WIDTH-bit operands with a 3-bit opcode over a valid/ready input channel and returns a registered result with carry, overflow, zero and sign flags over a valid/ready output channel. It adds a stored carry for multi-word add (ADC), a barrel shift, and an optional iterative multiply. It sits between the operand-fetch stage and the writeback/result logger.

## Interface
- WIDTH, 4: operand/result width; legal values 4..32.
- SHW, $clog2(WIDTH): derived shift-amount width; not overridable.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 SHL, 111 MUL
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- carry_out, overflow, zero, sign  out  1 each  result flags
- busy  out  1  multiply in progress

## Operation
- Accept: in_valid & in_ready. Consume: out_valid & out_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- States: IDLE, MUL.
  - IDLE→MUL on accept of op 111.
  - MUL→IDLE after WIDTH iterations.
- ADD: {carry_out, y} = a + b. overflow = (a[MSB]==b[MSB]) & (y[MSB]!=a[MSB]).
- SUB: y = a - b. carry_out = 1 when a >= b unsigned, i.e. NOT borrow. overflow = (a[MSB]!=b[MSB]) & (y[MSB]!=a[MSB]).
- ADC: {carry_out, y} = a + b + cflag. Overflow as for ADD.
- cflag:
  - An internal register loaded with carry_out on every ADD/SUB/ADC result load.
  - Unchanged by other ops.
  - Reset value 0.
- AND/OR/XOR: bitwise. carry_out = overflow = 0.
- SHL:
  - y = a << b[SHW-1:0]; upper bits of b are ignored.
  - carry_out = last bit shifted out, or 0 for a zero shift amount.
  - overflow = 0.
- MUL:
  - Unsigned shift-add, one partial product per cycle.
  - y = low WIDTH bits of the product.
  - carry_out = 1 if any high WIDTH bits are nonzero.
  - overflow = 0.
- All ops: zero = (y==0), sign = y[MSB].
- While out_valid & !out_ready: y and flags hold stable, in_ready = 0.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, busy = 0.
  - y = 0, carry_out = 0, overflow = 0, zero = 0, sign = 0.
  - cflag = 0, state = IDLE.
- Non-MUL ops: result registered on the accepting edge; out_valid high the next cycle. Latency 1.
- Back-to-back: one accept per cycle sustained while out_ready = 1.
- ADC accepted the cycle after an ADD uses that ADD's carry.
- MUL:
  - busy = 1 and in_ready = 0 for WIDTH cycles after accept.
  - Result loads on the WIDTH-th edge; out_valid rises the next cycle. Latency WIDTH+1.
- rst mid-MUL aborts: state IDLE, out_valid = 0, partial product discarded, cflag = 0.
- rst with out_valid pending: result dropped.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL implemented as above, sub-module instantiated.
- ALU_SEQ_MUL_EN undefined:
  - op 111 completes in 1 cycle with y = 0, zero = 1, all other flags 0.
  - busy tied 0. MUL state and multiplier are absent.

## Structure
- Package alu_seq_pkg holds:
  - op_e enum with the encodings above.
  - state_e enum (IDLE, MUL).
  - OP_W = 3.
- Sub-module alu_mul_iter:
  - Start/done handshake, WIDTH-parameterised shift-add multiplier.
  - Returns a 2×WIDTH product.
  - Compiled only under ALU_SEQ_MUL_EN.

## Test plan
Scenarios use WIDTH=8.
- ADD 0xFF + 0x01, out_ready = 1 → y = 0x00, carry_out = 1, zero = 1, overflow = 0, one cycle after accept.
- SUB 0x80 - 0x01 → y = 0x7F, carry_out = 1, overflow = 1, sign = 0. SUB 0x01 - 0x02 → y = 0xFF, carry_out = 0, sign = 1.
- ADD 0xF0 + 0x20, then ADC 0x00 + 0x00 on the next cycle → second result y = 0x01, carry_out = 0.
- MUL 0x10 × 0x11:
  - busy high 8 cycles.
  - y = 0x10, carry_out = 1.
  - out_valid rises 9 cycles after accept; in_ready low throughout.
- Hold out_ready = 0 for 5 cycles after XOR 0xAA ^ 0x0F → y = 0xA5 stable, in_ready = 0. Consume → in_ready = 1 the same cycle.
- Assert rst 3 cycles into MUL → next cycle: out_valid = 0, busy = 0, in_ready = 1. A following ADC 0x01 + 0x01 gives y = 0x02 (cflag cleared).

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode/state encodings and constants for the alu_seq_n datapath.
package alu_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    // Arithmetic ops whose carry_out is remembered for a following ADC.
    function automatic logic sets_cflag(input op_e op);
        return op inside {OP_ADD, OP_SUB, OP_ADC};
    endfunction

endpackage

// File: rtl/alu_seq_n_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// Only compiled when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic               run;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;

    // product is the accumulator including this cycle's partial product, so the
    // final sum is available combinationally on the last iteration.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = run && (cnt == CW'(WIDTH - 1));

    // NOTE: registers are written with <= so every flop samples pre-edge values;
    // blocking assignments here would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

    // NOTE: datapath registers carry no reset; they are reloaded on every start
    // and only observed while run is high.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (run) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule
`endif

// File: rtl/alu_seq_n.sv
// Handshaked WIDTH-bit ALU with stored carry (ADC), barrel shift and flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for op 111.
module alu_seq_n
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    op_e                op_cur;
    logic               accept;
    logic               mul_idle;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic               load;
    logic               cflag;
    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   res_y;
    logic               res_c;
    logic               res_v;

    assign op_cur   = op_e'(op);
    assign in_ready = mul_idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = (accept && !mul_start) || mul_done;

`ifdef ALU_SEQ_MUL_EN
    state_e state;

    assign mul_idle  = (state == IDLE);
    assign mul_start = accept && (op_cur == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mul_start) begin
                    state <= MUL;
                    busy  <= 1'b1;
                end
                MUL: if (mul_done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign mul_idle    = 1'b1;
    assign mul_start   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign busy        = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no path through
    // the case leaves a variable unassigned and infers a latch.
    always_comb begin
        wide  = '0;
        res_y = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        if (mul_done) begin
            res_y = mul_product[WIDTH-1:0];
            res_c = |mul_product[2*WIDTH-1:WIDTH];
        end else begin
            case (op_cur)
                OP_ADD: begin
                    wide  = {1'b0, a} + {1'b0, b};
                    res_y = wide[WIDTH-1:0];
                    res_c = wide[WIDTH];
                    res_v = (a[MSB] == b[MSB]) && (res_y[MSB] != a[MSB]);
                end
                OP_SUB: begin
                    wide  = {1'b0, a} - {1'b0, b};
                    res_y = wide[WIDTH-1:0];
                    res_c = !wide[WIDTH];  // carry is the inverted borrow
                    res_v = (a[MSB] != b[MSB]) && (res_y[MSB] != a[MSB]);
                end
                OP_ADC: begin
                    wide  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cflag};
                    res_y = wide[WIDTH-1:0];
                    res_c = wide[WIDTH];
                    res_v = (a[MSB] == b[MSB]) && (res_y[MSB] != a[MSB]);
                end
                OP_AND: res_y = a & b;
                OP_OR:  res_y = a | b;
                OP_XOR: res_y = a ^ b;
                OP_SHL: begin
                    // The extra top bit catches the last bit shifted out.
                    wide  = {1'b0, a} << b[SHW-1:0];
                    res_y = wide[WIDTH-1:0];
                    res_c = wide[WIDTH];
                end
                default: ;  // multiply result arrives via mul_done, or is zero when disabled
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
            cflag     <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                y         <= res_y;
                carry_out <= res_c;
                overflow  <= res_v;
                zero      <= (res_y == '0);
                sign      <= res_y[MSB];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && sets_cflag(op_cur)) cflag <= res_c;
        end
    end

endmodule

// File: tb/tb_alu_seq_n.sv
// Scoreboard bench for alu_seq_n at WIDTH=8; expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq_n;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [7:0] y;
        logic       c;
        logic       v;
        logic       z;
        logic       s;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       sign;
    logic       busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_wait;
    bit   rand_ready = 0;
    logic cf_model  = 1'b0;
    exp_t sb[$];

    alu_seq_n #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model in integer arithmetic; overflow is a signed range test.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] aa,
                                   input logic [7:0] bb, input logic cf);
        int          ua, ub, sa, sbv, r, sh;
        logic [31:0] rv;
        exp_t        e;
        ua  = int'(aa);
        ub  = int'(bb);
        sa  = int'($signed(aa));
        sbv = int'($signed(bb));
        e   = '0;
        r   = 0;
        case (o)
            OP_ADD: begin
                r   = ua + ub;
                e.c = (r > 255);
                e.v = (sa + sbv > 127) || (sa + sbv < -128);
            end
            OP_SUB: begin
                r   = ua - ub;
                e.c = (ua >= ub);
                e.v = (sa - sbv > 127) || (sa - sbv < -128);
            end
            OP_ADC: begin
                r   = ua + ub + int'(cf);
                e.c = (r > 255);
                e.v = (sa + sbv + int'(cf) > 127) || (sa + sbv + int'(cf) < -128);
            end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_SHL: begin
                sh  = ub % 8;
                r   = ua << sh;
                e.c = (sh != 0) && (((ua >> (8 - sh)) & 1) == 1);
            end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                r   = ua * ub;
                e.c = (r > 255);
`else
                r   = 0;
`endif
            end
        endcase
        rv  = r;
        e.y = rv[7:0];
        e.z = (e.y == 8'h00);
        e.s = e.y[7];
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb);
        bit   ok = 0;
        exp_t e;
        in_valid  = 1'b1;
        op        = o;
        a         = aa;
        b         = bb;
        last_wait = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
            last_wait++;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model(o, aa, bb, cf_model);
            if (o == OP_ADD || o == OP_SUB || o == OP_ADC) cf_model = e.c;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_y",        32'(y),         32'(e.y));
                check("out_carry",    32'(carry_out), 32'(e.c));
                check("out_overflow", 32'(overflow),  32'(e.v));
                check("out_zero",     32'(zero),      32'(e.z));
                check("out_sign",     32'(sign),      32'(e.s));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_y",         32'(y),         32'd0);
        check("rst_carry",     32'(carry_out), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        check("rst_sign",      32'(sign),      32'd0);
        @(posedge clk);
        #1;

        send(OP_ADD, 8'hFF, 8'h01);
        @(negedge clk);
        check("add_latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        send(OP_SUB, 8'h80, 8'h01);
        send(OP_SUB, 8'h01, 8'h02);
        send(OP_ADD, 8'hF0, 8'h20);
        send(OP_ADC, 8'h00, 8'h00);
        check("b2b_no_stall", 32'(last_wait), 32'd0);
        send(OP_AND, 8'hC3, 8'h5A);
        send(OP_OR,  8'h00, 8'h00);
        send(OP_SHL, 8'h81, 8'h01);
        send(OP_SHL, 8'hF0, 8'h00);
        send(OP_SHL, 8'h13, 8'h0B);
        send(OP_SHL, 8'h01, 8'hF7);

        send(OP_MUL, 8'h10, 8'h11);
`ifdef ALU_SEQ_MUL_EN
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("mul_busy",      32'(busy),      32'd1);
            check("mul_in_ready",  32'(in_ready),  32'd0);
            check("mul_out_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("mul_done_valid", 32'(out_valid), 32'd1);
        check("mul_done_busy",  32'(busy),      32'd0);
`else
        @(negedge clk);
        check("mul_off_valid", 32'(out_valid), 32'd1);
        check("mul_off_busy",  32'(busy),      32'd0);
`endif
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(OP_XOR, 8'hAA, 8'h0F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_y",        32'(y),         32'hA5);
            check("stall_in_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("consume_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(OP_ADD, 8'hFF, 8'h01);
        send(OP_MUL, 8'h03, 8'h05);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        cf_model = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        send(OP_ADC, 8'h01, 8'h01);

        rand_ready = 1;
        for (int k = 0; k < 30; k++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        rand_ready = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
